// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and arbiter state type
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } arb_state_t;

    // A burst in flight must not be split between masters.
    function automatic logic in_burst(input logic [1:0] trans);
        return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb_arb_resolve.sv
// rtl/ahb_arb_resolve.sv - combinational winner select from requests and tie pointer
module ahb_arb_resolve
    import ahb_pkg::*;
#(
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_ptr,
    output logic o_winner
);

    always_comb begin
        o_winner = DEFAULT_MASTER;
        if (i_req0 && i_req1) begin
            o_winner = i_ptr;
        end else if (i_req0) begin
            o_winner = 1'b0;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_ram_arbiter.sv
// rtl/ahb_ram_arbiter.sv - two-master AHB arbiter for the RAM slave
// Optional macro AHB_ARB_ROUND_ROBIN_EN: round-robin tie break instead of fixed m0 priority.
module ahb_ram_arbiter
    import ahb_pkg::*;
#(
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       hbusreq_m0,
    input  logic       hbusreq_m1,
    input  logic       hlock_m0,
    input  logic       hlock_m1,
    input  logic [1:0] htrans_m0,
    input  logic [1:0] htrans_m1,
    input  logic       hready,
    output logic       hgrant_m0,
    output logic       hgrant_m1,
    output logic       hmaster,
    output logic       hmaster_data,
    output logic       hmastlock
);

    localparam arb_state_t DEF_STATE = arb_state_t'(DEFAULT_MASTER);

    arb_state_t r_state;
    logic       r_hmaster_data;
    logic       r_hmastlock;

    logic       w_owner;
    logic [1:0] w_own_trans;
    logic       w_own_lock;
    logic       w_handover_ok;
    logic       w_ptr;
    logic       w_winner;

    assign w_owner       = (r_state == OWN_M1);
    assign w_own_trans   = w_owner ? htrans_m1 : htrans_m0;
    assign w_own_lock    = w_owner ? hlock_m1 : hlock_m0;
    assign w_handover_ok = !in_burst(w_own_trans) && !w_own_lock;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    ahb_arb_resolve #(
        .DEFAULT_MASTER(DEFAULT_MASTER)
    ) u_resolve (
        .i_req0   (hbusreq_m0),
        .i_req1   (hbusreq_m1),
        .i_ptr    (w_ptr),
        .o_winner (w_winner)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state        <= DEF_STATE;
            r_hmaster_data <= DEFAULT_MASTER;
            r_hmastlock    <= 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
            r_ptr          <= ~DEFAULT_MASTER;
`endif
        end else if (hready) begin
            r_hmaster_data <= w_owner;
            r_hmastlock    <= w_own_lock;
            if (w_handover_ok) begin
                r_state <= arb_state_t'(w_winner);
`ifdef AHB_ARB_ROUND_ROBIN_EN
                // The outgoing owner becomes the preferred master on the next tie.
                if (w_winner != w_owner) begin
                    r_ptr <= w_owner;
                end
`endif
            end
        end
    end

    assign hgrant_m0    = (r_state == OWN_M0);
    assign hgrant_m1    = (r_state == OWN_M1);
    assign hmaster      = w_owner;
    assign hmaster_data = r_hmaster_data;
    assign hmastlock    = r_hmastlock;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// tb/tb_ahb_ram_arbiter.sv - self-checking bench for ahb_ram_arbiter
module tb_ahb_ram_arbiter;

    localparam int D = 0;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       hbusreq_m0, hbusreq_m1;
    logic       hlock_m0, hlock_m1;
    logic [1:0] htrans_m0, htrans_m1;
    logic       hready;
    logic       hgrant_m0, hgrant_m1, hmaster, hmaster_data, hmastlock;

    int checks = 0;
    int errors = 0;

    int m_own, m_ptr, m_lock, m_data;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    ahb_ram_arbiter #(.DEFAULT_MASTER(1'b0)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .hbusreq_m0   (hbusreq_m0),
        .hbusreq_m1   (hbusreq_m1),
        .hlock_m0     (hlock_m0),
        .hlock_m1     (hlock_m1),
        .htrans_m0    (htrans_m0),
        .htrans_m1    (htrans_m1),
        .hready       (hready),
        .hgrant_m0    (hgrant_m0),
        .hgrant_m1    (hgrant_m1),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock)
    );

    always #5 HCLK = ~HCLK;

    // Ownership rules applied at one rising edge, from the currently driven inputs.
    task automatic model_edge();
        int tr, lk, win;
        if (HRESET) begin
            m_own = D; m_ptr = 1 - D; m_lock = 0; m_data = D;
        end else if (hready) begin
            tr = (m_own == 1) ? int'(htrans_m1) : int'(htrans_m0);
            lk = (m_own == 1) ? int'(hlock_m1) : int'(hlock_m0);
            m_data = m_own;
            m_lock = lk;
            if (tr != 3 && tr != 1 && lk == 0) begin
                if (hbusreq_m0 && hbusreq_m1) win = RR ? m_ptr : 0;
                else if (hbusreq_m0)          win = 0;
                else if (hbusreq_m1)          win = 1;
                else                          win = D;
                if (win != m_own) begin
                    m_ptr = m_own;
                    m_own = win;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        HRESET = 1'b0;
        hbusreq_m0 = 1'b0; hbusreq_m1 = 1'b0;
        hlock_m0 = 1'b0;   hlock_m1 = 1'b0;
        htrans_m0 = 2'b00; htrans_m1 = 2'b00;
        hready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        HRESET = 1'b1;
        hbusreq_m1 = 1'b1; hlock_m0 = 1'b1; htrans_m0 = 2'b11;
        tick();
        tick();
        checks++; if (hgrant_m0 !== 1'b1) begin errors++; $display("FAIL reset_hgrant_m0: got %b expected 1", hgrant_m0); end
        checks++; if (hgrant_m1 !== 1'b0) begin errors++; $display("FAIL reset_hgrant_m1: got %b expected 0", hgrant_m1); end
        checks++; if (hmaster !== 1'b0) begin errors++; $display("FAIL reset_hmaster: got %b expected 0", hmaster); end
        checks++; if (hmaster_data !== 1'b0) begin errors++; $display("FAIL reset_hmaster_data: got %b expected 0", hmaster_data); end
        checks++; if (hmastlock !== 1'b0) begin errors++; $display("FAIL reset_hmastlock: got %b expected 0", hmastlock); end
        set_idle();
    endtask

    task automatic test_single_request();
        do_reset();
        hbusreq_m1 = 1'b1; htrans_m1 = 2'b10;
        tick();
        checks++; if (hgrant_m1 !== 1'b1 || hgrant_m0 !== 1'b0) begin errors++; $display("FAIL single_grant: got m0=%b m1=%b expected m0=0 m1=1", hgrant_m0, hgrant_m1); end
        checks++; if (hmaster_data !== 1'b0) begin errors++; $display("FAIL single_data_lag: got %b expected 0", hmaster_data); end
        tick();
        checks++; if (hmaster_data !== 1'b1) begin errors++; $display("FAIL single_data: got %b expected 1", hmaster_data); end
    endtask

    task automatic test_burst_hold();
        do_reset();
        hbusreq_m0 = 1'b1; hbusreq_m1 = 1'b1;
        htrans_m0 = 2'b11; htrans_m1 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (hgrant_m0 !== 1'b1) begin errors++; $display("FAIL burst_hold beat %0d: got hgrant_m0=%b expected 1", i, hgrant_m0); end
        end
        htrans_m0 = 2'b00; hbusreq_m0 = 1'b0;
        tick();
        checks++; if (hgrant_m1 !== 1'b1) begin errors++; $display("FAIL burst_release: got hgrant_m1=%b expected 1", hgrant_m1); end
    endtask

    task automatic test_lock();
        do_reset();
        hlock_m0 = 1'b1; hbusreq_m0 = 1'b1; hbusreq_m1 = 1'b1;
        htrans_m0 = 2'b10; htrans_m1 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (hgrant_m0 !== 1'b1) begin errors++; $display("FAIL lock_grant cycle %0d: got %b expected 1", i, hgrant_m0); end
            checks++; if (hmastlock !== 1'b1) begin errors++; $display("FAIL lock_hmastlock cycle %0d: got %b expected 1", i, hmastlock); end
        end
        set_idle();
    endtask

    task automatic test_wait_state();
        do_reset();
        hbusreq_m0 = 1'b1; htrans_m0 = 2'b10;
        tick();
        hready = 1'b0; hbusreq_m0 = 1'b0; htrans_m0 = 2'b00;
        hbusreq_m1 = 1'b1; htrans_m1 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({hgrant_m0, hmaster, hmaster_data} !== 3'b100) begin
                errors++; $display("FAIL wait_frozen cycle %0d: got g0/hm/hmd=%b expected 100", i, {hgrant_m0, hmaster, hmaster_data});
            end
        end
        hready = 1'b1;
        tick();
        checks++; if (hgrant_m1 !== 1'b1 || hmaster_data !== 1'b0) begin errors++; $display("FAIL wait_release: got g1=%b hmd=%b expected g1=1 hmd=0", hgrant_m1, hmaster_data); end
        tick();
        checks++; if (hmaster_data !== 1'b1) begin errors++; $display("FAIL wait_data: got %b expected 1", hmaster_data); end
    endtask

    task automatic test_tie();
        logic exp_g1;
        do_reset();
        hbusreq_m0 = 1'b1; hbusreq_m1 = 1'b1;
        htrans_m0 = 2'b10; htrans_m1 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_g1 = RR ? ((i % 2) == 0) : 1'b0;
            checks++; if (hgrant_m1 !== exp_g1) begin errors++; $display("FAIL tie step %0d: got hgrant_m1=%b expected %b", i, hgrant_m1, exp_g1); end
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [4:0] exp, got;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            HRESET     = ($urandom_range(0, 49) == 0);
            hbusreq_m0 = 1'($urandom);
            hbusreq_m1 = 1'($urandom);
            hlock_m0   = ($urandom_range(0, 4) == 0);
            hlock_m1   = ($urandom_range(0, 4) == 0);
            htrans_m0  = 2'($urandom);
            htrans_m1  = 2'($urandom);
            hready     = ($urandom_range(0, 3) != 0);
            tick();
            exp = {m_own == 0, m_own == 1, m_own[0], m_data[0], m_lock[0]};
            got = {hgrant_m0, hgrant_m1, hmaster, hmaster_data, hmastlock};
            checks++; if (got !== exp) begin errors++; $display("FAIL random cycle %0d: got g0,g1,hm,hmd,lock=%b expected %b", i, got, exp); end
            checks++; if ((hgrant_m0 ^ hgrant_m1) !== 1'b1) begin errors++; $display("FAIL onehot cycle %0d: got g0=%b g1=%b expected exactly one", i, hgrant_m0, hgrant_m1); end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        m_own = D; m_ptr = 1 - D; m_lock = 0; m_data = D;
        test_reset();
        test_single_request();
        test_burst_hold();
        test_lock();
        test_wait_state();
        test_tie();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
